// File: rtl/writeback_trap_unit.sv
// writeback_trap_unit: final pipeline stage of the core.
// It commits register-file and CSR results. It also arbitrates interrupts,
// synchronous exceptions, mret and wfi into one trap request. It holds the
// WFI sleep state with a captured wake PC and the retired-instruction counter.
//
// Ports:
//   clk, reset_n                        clock, async active-low reset
//   valid_in, pc_in, next_pc_in         instruction from the memory stage
//   alu/csr/load_data_in, write_select_in, rd_address_in
//                                       result sources and destination
//   csr_address_in, csr_write_in, mret_in, wfi_in, exception_in, ecause_in
//   irq_pending, irq_enable, global_ie  interrupt lines, mie, mstatus.MIE
//   cnt_inhibit, cnt_wr_lo/hi, cnt_wdata
//                                       retire counter control and CSR writes
//   rd_address, rd_data                 regfile write (address 0 = no write)
//   csr_write, csr_address, csr_data    CSR file write
//   traped, interupt, ecause, ecp       trap request to fetch and the CSR file
//   mret, retired, sleeping, retire_count
module writeback_trap_unit #(
  parameter int                    XLEN      = 32,
  parameter int                    NIRQ      = 3,
  parameter logic [4*NIRQ-1:0]     IRQ_CAUSE = {4'd11, 4'd7, 4'd3},
  parameter int                    CNT_W     = 64
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic             valid_in,
  input  logic [XLEN-1:0]  pc_in,
  input  logic [XLEN-1:0]  next_pc_in,
  input  logic [XLEN-1:0]  alu_data_in,
  input  logic [XLEN-1:0]  csr_data_in,
  input  logic [XLEN-1:0]  load_data_in,
  input  logic [1:0]       write_select_in,
  input  logic [4:0]       rd_address_in,
  input  logic [11:0]      csr_address_in,
  input  logic             csr_write_in,
  input  logic             mret_in,
  input  logic             wfi_in,
  input  logic             exception_in,
  input  logic [3:0]       ecause_in,
  input  logic [NIRQ-1:0]  irq_pending,
  input  logic [NIRQ-1:0]  irq_enable,
  input  logic             global_ie,
  input  logic             cnt_inhibit,
  input  logic             cnt_wr_lo,
  input  logic             cnt_wr_hi,
  input  logic [XLEN-1:0]  cnt_wdata,
  output logic [4:0]       rd_address,
  output logic [XLEN-1:0]  rd_data,
  output logic             csr_write,
  output logic [11:0]      csr_address,
  output logic [XLEN-1:0]  csr_data,
  output logic             traped,
  output logic             interupt,
  output logic [3:0]       ecause,
  output logic [XLEN-1:0]  ecp,
  output logic             mret,
  output logic             retired,
  output logic             sleeping,
  output logic [CNT_W-1:0] retire_count
);

  typedef enum logic {RUN, SLEEP} state_e;

  state_e           state_q, state_d;
  logic [XLEN-1:0]  wake_pc_q, wake_pc_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;

  logic [NIRQ-1:0]  irq_live;   // enabled and pending, ignoring global_ie
  logic [NIRQ-1:0]  irq_take;
  logic [3:0]       irq_cause;
  logic             in_sleep, valid_eff, irq_trap, exc_trap, to_execute;

  assign in_sleep  = (state_q == SLEEP);
  // While asleep the memory stage is stalled, so its contents are ignored.
  assign valid_eff = valid_in && !in_sleep;
  assign irq_live  = irq_pending & irq_enable;
  assign irq_take  = global_ie ? irq_live : '0;

  // Ascending scan: the highest set index is written last, so it wins.
  always_comb begin
    irq_cause = 4'd0;
    for (int i = 0; i < NIRQ; i++)
      if (irq_take[i]) irq_cause = IRQ_CAUSE[4*i +: 4];
  end

  assign irq_trap   = (|irq_take) && (valid_in || in_sleep);
  assign exc_trap   = exception_in && valid_eff;
  assign to_execute = valid_eff && !exception_in;

  assign traped   = irq_trap || exc_trap;
  assign interupt = irq_trap;
  assign ecause   = irq_trap ? irq_cause : (exc_trap ? ecause_in : 4'd0);
  assign ecp      = in_sleep ? wake_pc_q : (wfi_in ? next_pc_in : pc_in);

  assign retired     = to_execute && !traped;
  assign mret        = mret_in && retired;
  assign csr_write   = csr_write_in && retired;
  assign csr_address = csr_address_in;
  assign csr_data    = alu_data_in;
  assign rd_address  = retired ? rd_address_in : 5'd0;

  always_comb begin
    case (write_select_in)
      2'd0:    rd_data = alu_data_in;
      2'd1:    rd_data = csr_data_in;
      2'd2:    rd_data = load_data_in;
      default: rd_data = next_pc_in;
    endcase
  end

  // Sleep FSM. A wfi that retires while an enabled IRQ is already pending
  // acts as a nop. Wake-up ignores global_ie: with it clear, the core resumes
  // silently at the following instruction.
  always_comb begin
    state_d   = state_q;
    wake_pc_d = wake_pc_q;
    case (state_q)
      RUN:
        if (retired && wfi_in && !(|irq_live)) begin
          state_d   = SLEEP;
          wake_pc_d = next_pc_in;
        end
      SLEEP:
        if (|irq_live) state_d = RUN;
      default: state_d = RUN;
    endcase
  end

  assign sleeping = in_sleep;

  // Retire counter. A CSR write to either half suppresses the increment for
  // the whole counter. The half that is not written keeps its value.
  logic [CNT_W-1:0] hi_mask, hi_wdata;
  assign hi_mask  = {CNT_W{1'b1}} << XLEN;
  assign hi_wdata = CNT_W'(cnt_wdata) << XLEN;

  always_comb begin
    cnt_d = cnt_q;
    if (cnt_wr_lo || cnt_wr_hi) begin
      if (cnt_wr_lo) cnt_d[XLEN-1:0] = cnt_wdata;
      if (cnt_wr_hi) cnt_d = (cnt_d & ~hi_mask) | (hi_wdata & hi_mask);
    end else if (retired && !cnt_inhibit) begin
      cnt_d = cnt_q + CNT_W'(1);
    end
  end

  assign retire_count = cnt_q;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q   <= RUN;
      wake_pc_q <= '0;
      cnt_q     <= '0;
    end else begin
      state_q   <= state_d;
      wake_pc_q <= wake_pc_d;
      cnt_q     <= cnt_d;
    end
  end

endmodule

// File: tb/tb_writeback_trap_unit.sv
module tb_writeback_trap_unit;
  logic        clk = 1'b0;
  logic        reset_n;
  logic        valid_in;
  logic [31:0] pc_in, next_pc_in, alu_data_in, csr_data_in, load_data_in;
  logic [1:0]  write_select_in;
  logic [4:0]  rd_address_in;
  logic [11:0] csr_address_in;
  logic        csr_write_in, mret_in, wfi_in, exception_in;
  logic [3:0]  ecause_in;
  logic [2:0]  irq_pending, irq_enable;
  logic        global_ie, cnt_inhibit, cnt_wr_lo, cnt_wr_hi;
  logic [31:0] cnt_wdata;
  logic [4:0]  rd_address;
  logic [31:0] rd_data, csr_data, ecp;
  logic        csr_write, traped, interupt, mret, retired, sleeping;
  logic [11:0] csr_address;
  logic [3:0]  ecause;
  logic [63:0] retire_count;

  int n_cmp = 0;
  int n_err = 0;

  writeback_trap_unit dut (
    .clk(clk), .reset_n(reset_n), .valid_in(valid_in), .pc_in(pc_in),
    .next_pc_in(next_pc_in), .alu_data_in(alu_data_in), .csr_data_in(csr_data_in),
    .load_data_in(load_data_in), .write_select_in(write_select_in),
    .rd_address_in(rd_address_in), .csr_address_in(csr_address_in),
    .csr_write_in(csr_write_in), .mret_in(mret_in), .wfi_in(wfi_in),
    .exception_in(exception_in), .ecause_in(ecause_in), .irq_pending(irq_pending),
    .irq_enable(irq_enable), .global_ie(global_ie), .cnt_inhibit(cnt_inhibit),
    .cnt_wr_lo(cnt_wr_lo), .cnt_wr_hi(cnt_wr_hi), .cnt_wdata(cnt_wdata),
    .rd_address(rd_address), .rd_data(rd_data), .csr_write(csr_write),
    .csr_address(csr_address), .csr_data(csr_data), .traped(traped),
    .interupt(interupt), .ecause(ecause), .ecp(ecp), .mret(mret),
    .retired(retired), .sleeping(sleeping), .retire_count(retire_count)
  );

  always #5 clk = ~clk;

  task automatic idle();
    valid_in = 0; pc_in = 32'h0; next_pc_in = 32'h4;
    alu_data_in = 0; csr_data_in = 0; load_data_in = 0;
    write_select_in = 0; rd_address_in = 0; csr_address_in = 0;
    csr_write_in = 0; mret_in = 0; wfi_in = 0; exception_in = 0; ecause_in = 0;
    irq_pending = 0; irq_enable = 0; global_ie = 0;
    cnt_inhibit = 0; cnt_wr_lo = 0; cnt_wr_hi = 0; cnt_wdata = 0;
  endtask

  task automatic apply_reset();
    @(negedge clk);
    idle();
    reset_n = 0;
    #2;
    @(negedge clk);
    reset_n = 1;
  endtask

  task automatic test_reset();
    @(negedge clk);
    idle();
    reset_n = 0;
    valid_in = 1; rd_address_in = 5'd9; alu_data_in = 32'hABCD;
    #1;
    n_cmp++; if (retire_count !== 64'd0) begin n_err++; $display("FAIL reset_count got %h exp 0", retire_count); end
    n_cmp++; if (sleeping !== 1'b0) begin n_err++; $display("FAIL reset_sleeping got %b exp 0", sleeping); end
    n_cmp++; if (rd_address !== 5'd9 || rd_data !== 32'hABCD) begin n_err++; $display("FAIL reset_comb got rd=%0d data=%h exp 9/abcd", rd_address, rd_data); end
    @(posedge clk); #1;
    n_cmp++; if (retire_count !== 64'd0) begin n_err++; $display("FAIL reset_hold_count got %h exp 0", retire_count); end
    @(negedge clk); idle(); reset_n = 1;
  endtask

  task automatic test_alu();
    apply_reset();
    valid_in = 1; write_select_in = 0; rd_address_in = 5; alu_data_in = 32'h1234;
    csr_write_in = 1; csr_address_in = 12'h340;
    #1;
    n_cmp++; if (rd_address !== 5'd5 || rd_data !== 32'h1234) begin n_err++; $display("FAIL alu_rd got %0d/%h exp 5/1234", rd_address, rd_data); end
    n_cmp++; if (retired !== 1 || traped !== 0 || csr_write !== 1 || csr_data !== 32'h1234 || csr_address !== 12'h340) begin n_err++; $display("FAIL alu_commit got ret=%b trap=%b csrw=%b csrd=%h csra=%h exp 1/0/1/1234/340", retired, traped, csr_write, csr_data, csr_address); end
    n_cmp++; if (retire_count !== 64'd0) begin n_err++; $display("FAIL alu_count_pre got %h exp 0", retire_count); end
    @(posedge clk); #1;
    n_cmp++; if (retire_count !== 64'd1) begin n_err++; $display("FAIL alu_count got %h exp 1", retire_count); end
    // other writeback sources
    @(negedge clk);
    csr_write_in = 0; write_select_in = 1; csr_data_in = 32'hC5; load_data_in = 32'h1D; next_pc_in = 32'h108; mret_in = 1;
    #1;
    n_cmp++; if (rd_data !== 32'hC5 || mret !== 1) begin n_err++; $display("FAIL sel_csr got %h mret=%b exp c5/1", rd_data, mret); end
    @(negedge clk); write_select_in = 2; mret_in = 0; #1;
    n_cmp++; if (rd_data !== 32'h1D) begin n_err++; $display("FAIL sel_load got %h exp 1d", rd_data); end
    @(negedge clk); write_select_in = 3; #1;
    n_cmp++; if (rd_data !== 32'h108) begin n_err++; $display("FAIL sel_npc got %h exp 108", rd_data); end
    @(posedge clk); #1;
    n_cmp++; if (retire_count !== 64'd4) begin n_err++; $display("FAIL sel_count got %h exp 4", retire_count); end
  endtask

  task automatic test_exception();
    apply_reset();
    valid_in = 1; exception_in = 1; ecause_in = 2; pc_in = 32'h100; next_pc_in = 32'h104;
    rd_address_in = 3; csr_write_in = 1; mret_in = 1;
    #1;
    n_cmp++; if (traped !== 1 || ecause !== 4'd2 || interupt !== 0 || ecp !== 32'h100) begin n_err++; $display("FAIL exc_trap got t=%b c=%0d i=%b ecp=%h exp 1/2/0/100", traped, ecause, interupt, ecp); end
    n_cmp++; if (rd_address !== 0 || retired !== 0 || csr_write !== 0 || mret !== 0) begin n_err++; $display("FAIL exc_nocommit got rd=%0d ret=%b csrw=%b mret=%b exp 0/0/0/0", rd_address, retired, csr_write, mret); end
    @(posedge clk); #1;
    n_cmp++; if (retire_count !== 64'd0) begin n_err++; $display("FAIL exc_count got %h exp 0", retire_count); end
    // exception without valid is not a trap
    @(negedge clk); valid_in = 0; #1;
    n_cmp++; if (traped !== 0 || ecause !== 0) begin n_err++; $display("FAIL exc_novalid got t=%b c=%0d exp 0/0", traped, ecause); end
  endtask

  task automatic test_irq_priority();
    apply_reset();
    valid_in = 1; exception_in = 1; ecause_in = 2; irq_pending = 3'b111; irq_enable = 3'b011;
    global_ie = 1; csr_write_in = 1; rd_address_in = 4;
    #1;
    n_cmp++; if (traped !== 1 || ecause !== 4'd7 || interupt !== 1) begin n_err++; $display("FAIL irq_prio got t=%b c=%0d i=%b exp 1/7/1", traped, ecause, interupt); end
    n_cmp++; if (csr_write !== 0 || rd_address !== 0 || retired !== 0) begin n_err++; $display("FAIL irq_nocommit got csrw=%b rd=%0d ret=%b exp 0/0/0", csr_write, rd_address, retired); end
    // only line 0 enabled -> cause 3
    @(negedge clk); exception_in = 0; irq_enable = 3'b001; #1;
    n_cmp++; if (ecause !== 4'd3 || traped !== 1) begin n_err++; $display("FAIL irq_line0 got c=%0d t=%b exp 3/1", ecause, traped); end
    // no valid instruction in RUN -> interrupt ignored
    @(negedge clk); valid_in = 0; #1;
    n_cmp++; if (traped !== 0 || interupt !== 0) begin n_err++; $display("FAIL irq_novalid got t=%b i=%b exp 0/0", traped, interupt); end
    // global_ie clear -> instruction retires
    @(negedge clk); valid_in = 1; global_ie = 0; #1;
    n_cmp++; if (traped !== 0 || retired !== 1 || rd_address !== 5'd4) begin n_err++; $display("FAIL irq_gie0 got t=%b ret=%b rd=%0d exp 0/1/4", traped, retired, rd_address); end
  endtask

  task automatic test_wfi();
    apply_reset();
    valid_in = 1; wfi_in = 1; pc_in = 32'h200; next_pc_in = 32'h204;
    #1;
    n_cmp++; if (retired !== 1 || traped !== 0) begin n_err++; $display("FAIL wfi_retire got ret=%b t=%b exp 1/0", retired, traped); end
    @(posedge clk); #1;
    n_cmp++; if (sleeping !== 1) begin n_err++; $display("FAIL wfi_sleep got %b exp 1", sleeping); end
    @(negedge clk);
    wfi_in = 0; pc_in = 32'h300; next_pc_in = 32'h304; rd_address_in = 7; exception_in = 1; ecause_in = 5;
    #1;
    n_cmp++; if (retired !== 0 || rd_address !== 0 || traped !== 0) begin n_err++; $display("FAIL sleep_ignore got ret=%b rd=%0d t=%b exp 0/0/0", retired, rd_address, traped); end
    @(posedge clk); #1;
    n_cmp++; if (sleeping !== 1 || retire_count !== 64'd1) begin n_err++; $display("FAIL sleep_hold got s=%b cnt=%h exp 1/1", sleeping, retire_count); end
    @(negedge clk);
    valid_in = 0; exception_in = 0; irq_pending = 3'b100; irq_enable = 3'b100; global_ie = 1;
    #1;
    n_cmp++; if (traped !== 1 || ecause !== 4'd11 || interupt !== 1 || ecp !== 32'h204) begin n_err++; $display("FAIL wake_trap got t=%b c=%0d i=%b ecp=%h exp 1/11/1/204", traped, ecause, interupt, ecp); end
    @(posedge clk); #1;
    n_cmp++; if (sleeping !== 0) begin n_err++; $display("FAIL wake_run got %b exp 0", sleeping); end
  endtask

  task automatic test_wfi_nop();
    apply_reset();
    valid_in = 1; wfi_in = 1; next_pc_in = 32'h50; irq_pending = 3'b010; irq_enable = 3'b010;
    #1;
    n_cmp++; if (retired !== 1 || traped !== 0) begin n_err++; $display("FAIL wfinop_ret got ret=%b t=%b exp 1/0", retired, traped); end
    @(posedge clk); #1;
    n_cmp++; if (sleeping !== 0 || retire_count !== 64'd1) begin n_err++; $display("FAIL wfinop_state got s=%b cnt=%h exp 0/1", sleeping, retire_count); end
  endtask

  task automatic test_wake_silent();
    apply_reset();
    valid_in = 1; wfi_in = 1; next_pc_in = 32'h80;
    @(negedge clk); valid_in = 0; wfi_in = 0;
    irq_pending = 3'b001; irq_enable = 3'b001; global_ie = 0;
    #1;
    n_cmp++; if (sleeping !== 1 || traped !== 0) begin n_err++; $display("FAIL silent_wake got s=%b t=%b exp 1/0", sleeping, traped); end
    @(posedge clk); #1;
    n_cmp++; if (sleeping !== 0) begin n_err++; $display("FAIL silent_run got %b exp 0", sleeping); end
    @(negedge clk); valid_in = 1; rd_address_in = 12; alu_data_in = 32'h77; #1;
    n_cmp++; if (retired !== 1 || rd_address !== 5'd12) begin n_err++; $display("FAIL silent_next got ret=%b rd=%0d exp 1/12", retired, rd_address); end
    @(posedge clk); #1;
    n_cmp++; if (retire_count !== 64'd2) begin n_err++; $display("FAIL silent_count got %h exp 2", retire_count); end
  endtask

  task automatic test_reset_sleep();
    apply_reset();
    valid_in = 1; wfi_in = 1; next_pc_in = 32'h90;
    @(negedge clk); idle(); #1;
    n_cmp++; if (sleeping !== 1) begin n_err++; $display("FAIL rs_sleep got %b exp 1", sleeping); end
    reset_n = 0; #1;
    n_cmp++; if (sleeping !== 0 || retire_count !== 64'd0) begin n_err++; $display("FAIL rs_async got s=%b cnt=%h exp 0/0", sleeping, retire_count); end
    @(negedge clk); reset_n = 1;
  endtask

  task automatic test_counter();
    apply_reset();
    valid_in = 1; cnt_wr_hi = 1; cnt_wdata = 32'h0;
    @(negedge clk); cnt_wr_hi = 0; cnt_wr_lo = 1; cnt_wdata = 32'hFFFF_FFFF;
    @(negedge clk); cnt_wr_lo = 0;
    #1;
    n_cmp++; if (retire_count !== 64'h0000_0000_FFFF_FFFF) begin n_err++; $display("FAIL cnt_wrlo got %h exp ffffffff", retire_count); end
    @(posedge clk); #1;
    n_cmp++; if (retire_count !== 64'h0000_0001_0000_0000) begin n_err++; $display("FAIL cnt_carry got %h exp 100000000", retire_count); end
    @(negedge clk); cnt_wr_hi = 1; cnt_wdata = 32'hA;
    @(posedge clk); #1;
    n_cmp++; if (retire_count !== 64'h0000_000A_0000_0000) begin n_err++; $display("FAIL cnt_wrhi got %h exp a00000000", retire_count); end
    @(negedge clk); cnt_wr_hi = 0; cnt_inhibit = 1;
    @(posedge clk); #1;
    n_cmp++; if (retire_count !== 64'h0000_000A_0000_0000) begin n_err++; $display("FAIL cnt_inhibit got %h exp a00000000", retire_count); end
    @(negedge clk); cnt_inhibit = 0; cnt_wr_lo = 1; cnt_wr_hi = 1; cnt_wdata = 32'hFFFF_FFFF;
    @(negedge clk); cnt_wr_lo = 0; cnt_wr_hi = 0;
    @(posedge clk); #1;
    n_cmp++; if (retire_count !== 64'h0) begin n_err++; $display("FAIL cnt_wrap got %h exp 0", retire_count); end
  endtask

  initial begin
    idle();
    reset_n = 1;
    test_reset();
    test_alu();
    test_exception();
    test_irq_priority();
    test_wfi();
    test_wfi_nop();
    test_wake_silent();
    test_reset_sleep();
    test_counter();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule
